// File: rtl/button_pio_irq_servicer_pkg.sv
// Shared definitions for the button PIO servicer: register map, FSM states
// and the event record width helper.
package button_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  typedef enum logic [3:0] {
    WR_MASK,
    IDLE,
    RD_EDGE,
    RD_EDGE_W,
    CLR_EDGE,
    RD_DATA,
    RD_DATA_W,
    PUSH,
    HOLD
  } state_t;

  // An event carries {edges, levels}, one bit of each per button.
  function automatic int evt_width(input int n_btn);
    return 2 * n_btn;
  endfunction

endpackage

// File: rtl/button_pio_irq_servicer_if.sv
// Avalon-MM bus between the servicer (master) and the button PIO (slave).
interface button_pio_irq_servicer_if;

  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata
  );

endinterface

// File: rtl/button_pio_irq_servicer_fifo.sv
// Synchronous first-word-fall-through FIFO holding button events.
module button_evt_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is accepted when a pop frees a slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign empty   = (count == '0);
  assign full    = (count == (PW + 1)'(DEPTH));
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/button_pio_irq_servicer.sv
// Owns the button PIO: programs its irq mask, services edge interrupts and
// queues {edges, levels} events for the downstream controller.
module button_pio_irq_servicer
  import button_pio_pkg::*;
#(
  parameter int               N_BTN      = 2,
  parameter logic [N_BTN-1:0] MASK_INIT  = 2'b11,
  parameter int               FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  button_pio_irq_servicer_if.master avm,
  input  logic                      pio_irq,
  input  logic                      cfg_mask_wr,
  input  logic [N_BTN-1:0]          cfg_mask,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [N_BTN-1:0]          evt_edges,
  output logic [N_BTN-1:0]          evt_level,
  output logic                      overflow,
  output logic [7:0]                drop_count,
  output logic                      busy
);

  localparam int EW = evt_width(N_BTN);

  state_t           state;
  state_t           state_nxt;
  logic [N_BTN-1:0] pending_mask;
  logic             mask_pend;
  logic [N_BTN-1:0] cap_edges;
  logic [N_BTN-1:0] cap_level;
  logic [1:0]       bus_addr;
  logic             bus_cs;
  logic             bus_write_n;
  logic [31:0]      bus_wdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic [EW-1:0]    fifo_dout;
  logic [N_BTN-1:0] rdata_btn;
  logic             unused_rdata_hi;

  assign rdata_btn       = avm.avm_readdata[N_BTN-1:0];
  assign unused_rdata_hi = ^avm.avm_readdata[31:N_BTN];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WR_MASK;
    end else begin
      state <= state_nxt;
    end
  end

  // Bus outputs decode the current state; reset forces the bus idle so an
  // interrupted sequence issues no further PIO cycles.
  always_comb begin
    state_nxt   = state;
    bus_addr    = PIO_ADDR_DATA;
    bus_cs      = 1'b0;
    bus_write_n = 1'b1;
    bus_wdata   = '0;
    case (state)
      WR_MASK: begin
        bus_addr               = PIO_ADDR_MASK;
        bus_cs                 = 1'b1;
        bus_write_n            = 1'b0;
        bus_wdata[N_BTN-1:0]   = pending_mask;
        state_nxt              = IDLE;
      end
      IDLE: begin
        if (mask_pend) begin
          state_nxt = WR_MASK;
        end else if (pio_irq) begin
          state_nxt = RD_EDGE;
        end
      end
      RD_EDGE: begin
        bus_addr  = PIO_ADDR_EDGE;
        bus_cs    = 1'b1;
        state_nxt = RD_EDGE_W;
      end
      RD_EDGE_W: state_nxt = (rdata_btn == '0) ? IDLE : CLR_EDGE;
      CLR_EDGE: begin
        bus_addr             = PIO_ADDR_EDGE;
        bus_cs               = 1'b1;
        bus_write_n          = 1'b0;
        bus_wdata[N_BTN-1:0] = cap_edges;
        state_nxt            = RD_DATA;
      end
      RD_DATA: begin
        bus_addr  = PIO_ADDR_DATA;
        bus_cs    = 1'b1;
        state_nxt = RD_DATA_W;
      end
      RD_DATA_W: state_nxt = PUSH;
      PUSH:      state_nxt = HOLD;
      HOLD:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (reset) begin
      bus_addr    = PIO_ADDR_DATA;
      bus_cs      = 1'b0;
      bus_write_n = 1'b1;
      bus_wdata   = '0;
    end
  end

  assign avm.avm_address    = bus_addr;
  assign avm.avm_chipselect = bus_cs;
  assign avm.avm_write_n    = bus_write_n;
  assign avm.avm_writedata  = bus_wdata;

  // A new mask request always wins, even in WR_MASK, so it is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_mask <= MASK_INIT;
      mask_pend    <= 1'b0;
      cap_edges    <= '0;
      cap_level    <= '0;
      overflow     <= 1'b0;
      drop_count   <= '0;
    end else begin
      if (cfg_mask_wr) begin
        pending_mask <= cfg_mask;
        mask_pend    <= 1'b1;
      end else if (state == WR_MASK) begin
        mask_pend <= 1'b0;
      end
      if (state == RD_EDGE_W) begin
        cap_edges <= rdata_btn;
      end
      if (state == RD_DATA_W) begin
        cap_level <= rdata_btn;
      end
      if (state == PUSH && fifo_full && !fifo_pop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
      end
    end
  end

  assign fifo_push = (state == PUSH);
  assign fifo_pop  = evt_ready && !fifo_empty;

  button_evt_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({cap_edges, cap_level}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign evt_edges = fifo_dout[EW-1:N_BTN];
  assign evt_level = fifo_dout[N_BTN-1:0];
  assign busy      = (state != IDLE);

endmodule

// File: doc/button_pio_irq_servicer.md
Name: button_pio_irq_servicer

Overview:
- Avalon-MM master that owns the button PIO slave. Programs its IRQ mask after reset and at runtime on request.
- On PIO irq: reads the edge-capture register, clears exactly the captured bits, then samples the live button levels.
- Pushes one {edges, levels} event into a small FIFO consumed by the gait/mode controller, so software and other logic never touch the PIO directly.

Parameters:
- N_BTN, 2, number of button bits in the PIO (bits [N_BTN-1:0] used; upper writedata bits driven 0).
- MASK_INIT, 2'b11, irq_mask value written after reset.
- FIFO_DEPTH, 4, event FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- avm_address  out  2  PIO register address.
- avm_chipselect  out  1  PIO select.
- avm_write_n  out  1  active-low write strobe.
- avm_writedata  out  32  write data.
- avm_readdata  in  32  PIO read data; fixed read latency 1, no waitrequest.
- pio_irq  in  1  PIO interrupt (level).
- cfg_mask_wr  in  1  one-cycle request to reprogram mask.
- cfg_mask  in  N_BTN  new mask value, sampled with cfg_mask_wr.
- evt_valid  out  1  FIFO not empty.
- evt_ready  in  1  consumer pop.
- evt_edges  out  N_BTN  falling edges captured (head entry).
- evt_level  out  N_BTN  button levels after clear (head entry).
- overflow  out  1  sticky: event dropped on full FIFO.
- drop_count  out  8  dropped events, saturates at 255.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: all avm_* deasserted (chipselect 0, write_n 1, address 0, writedata 0); FIFO flushed; evt_valid 0; overflow 0; drop_count 0; pending_mask ← MASK_INIT; FSM → WR_MASK. Reset mid-sequence aborts the access with no further PIO cycles.
- FSM states:
  - WR_MASK: one cycle, address 2, cs 1, write_n 0, writedata = pending_mask. → IDLE.
  - IDLE: priority order is (1) mask request pending → WR_MASK; (2) pio_irq → RD_EDGE; (3) stay.
  - RD_EDGE: address 3, cs 1, write_n 1. → RD_EDGE_W.
  - RD_EDGE_W: bus idle; cap_edges ← avm_readdata[N_BTN-1:0]. If 0 → IDLE (spurious, no clear, no event); else → CLR_EDGE.
  - CLR_EDGE: address 3, cs 1, write_n 0, writedata = cap_edges (write-1-to-clear only captured bits, so edges arriving mid-sequence are kept). → RD_DATA.
  - RD_DATA: address 0, cs 1, write_n 1. → RD_DATA_W.
  - RD_DATA_W: cap_level ← avm_readdata[N_BTN-1:0]. → PUSH.
  - PUSH: push {cap_edges, cap_level} if FIFO not full. If full: drop the event, set overflow, increment drop_count (saturating). → HOLD.
  - HOLD: one idle cycle so the registered irq deasserts after the clear. → IDLE.
- Mask requests:
  - cfg_mask_wr in any state latches cfg_mask into pending_mask and sets mask_pend.
  - Serviced at the next IDLE; mask_pend cleared in WR_MASK.
  - A later request overwrites an earlier unserviced one.
- Latency:
  - pio_irq sampled high in IDLE at cycle t → RD_EDGE at t+1, CLR_EDGE at t+3, PUSH at t+6.
  - evt_valid high at t+7 if the FIFO was empty.
- FIFO behaviour:
  - First-word-fall-through; pop when evt_valid && evt_ready.
  - Simultaneous push and pop when full is allowed: no drop.
  - Pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
  - evt_edges/evt_level are don't-care when evt_valid is 0.
- Bus: at most one access per cycle. write_n = 1 whenever cs = 0. avm_writedata bits [31:N_BTN] always 0.

Decomposition:
- Shared package button_pio_pkg:
  - PIO_ADDR_DATA=0, PIO_ADDR_MASK=2, PIO_ADDR_EDGE=3.
  - FSM state encoding (WR_MASK, IDLE, RD_EDGE, RD_EDGE_W, CLR_EDGE, RD_DATA, RD_DATA_W, PUSH, HOLD).
  - Event record width 2*N_BTN.
- One sub-module: button_evt_fifo, a synchronous FWFT FIFO (params WIDTH, DEPTH; ports push, pop, full, empty, din, dout).

Test Plan:
- Reset release → cycle 1: address 2, write_n 0, writedata 0x3; then bus idle and busy 0.
- PIO model edge_capture=0b01, level=0b10, irq high → reads addr3, writes 0x1 to addr3, reads addr0; event {edges=01, level=10} valid at t+7.
- Button 1 falls between RD_EDGE and CLR_EDGE → clear writes 0x1 only; irq re-asserts; second event with edges=10 follows.
- evt_ready held 0, 6 irq events → 4 queued, overflow 1, drop_count 2; pop all in order, then evt_valid 0.
- cfg_mask_wr with 0b10 during RD_DATA → completes current event, then WR_MASK writes 0x2 before the next irq service.
- irq with edge_capture reading 0 → no write, no event, returns to IDLE after RD_EDGE_W.
